// File: rtl/dac_spi_tx.sv
// dac_spi_tx: signed sample -> DAC code -> MSB-first SPI frame; DAC_GAIN_EN adds Q1.15 saturating gain.
// Rev 1.0
`default_nettype none

module dac_spi_tx #(
  parameter int DATA_W        = 16,
  parameter int CLK_DIV       = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int OFFSET_BINARY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [15:0]       gain,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_sdo,
  output logic              frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               frame_done_q, frame_done_d;

  logic [DATA_W-1:0]  s_val;
  logic [DATA_W-1:0]  word;

`ifdef DAC_GAIN_EN
  localparam int PW = DATA_W + 17;

  logic signed [PW-1:0] mul_a, mul_b, prod;
  logic [PW-16:0]       prod_hi;
  logic                 unused_prod_lsbs;

  // Top three bits of the shifted product must agree for the value to fit in DATA_W.
  always_comb begin
    mul_a   = {{17{sample[DATA_W-1]}}, sample};
    mul_b   = {{DATA_W{1'b0}}, 1'b0, gain};
    prod    = mul_a * mul_b;
    prod_hi = prod[PW-1:15];
    if ((&prod_hi[PW-16:DATA_W-1]) || !(|prod_hi[PW-16:DATA_W-1])) begin
      s_val = prod_hi[DATA_W-1:0];
    end else if (prod_hi[PW-16]) begin
      s_val = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      s_val = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  assign unused_prod_lsbs = ^prod[14:0];
`else
  logic unused_gain;

  assign s_val       = sample;
  assign unused_gain = ^gain;
`endif

  assign word = (OFFSET_BINARY != 0) ? {~s_val[DATA_W-1], s_val[DATA_W-2:0]} : s_val;

  assign sample_ready = (state_q == S_IDLE) && !reset;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sample_valid && sample_ready) begin
          state_d   = S_SHIFT;
          shreg_d   = word;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
        end
      end

      S_SHIFT: begin
        if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of a high phase: next bit appears with the falling sclk; zeros fill in behind.
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              state_d      = S_GAP;
              cs_n_d       = 1'b1;
              gap_cnt_d    = '0;
              frame_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        shreg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dac_cs_n   = cs_n_q;
  assign dac_sclk   = sclk_q;
  assign dac_sdo    = shreg_q[DATA_W-1];
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: bench for dac_spi_tx (default instance plus OFFSET_BINARY=0/CLK_DIV=1 instance).
`default_nettype none

module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample0, gain0, exp0, sample1, gain1, exp1;
  logic        valid0, valid1;
  logic        ready0, cs0, sclk0, sdo0, fd0;
  logic        ready1, cs1, sclk1, sdo1, fd1;

  always #5 clk = ~clk;

  dac_spi_tx u_dut0 (
    .clk(clk), .reset(reset), .sample(sample0), .sample_valid(valid0), .sample_ready(ready0),
    .gain(gain0), .dac_cs_n(cs0), .dac_sclk(sclk0), .dac_sdo(sdo0), .frame_done(fd0)
  );

  dac_spi_tx #(.DATA_W(16), .CLK_DIV(1), .GAP_CYCLES(2), .OFFSET_BINARY(0)) u_dut1 (
    .clk(clk), .reset(reset), .sample(sample1), .sample_valid(valid1), .sample_ready(ready1),
    .gain(gain1), .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_sdo(sdo1), .frame_done(fd1)
  );

  typedef struct {
    logic [15:0] smp;
    logic [15:0] gn;
    logic [15:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          low_c[2], edge_c[2], frames[2], fd_c[2], accepts[2], last_acc[2];
  bit          streak[2], prev_cs[2], prev_sclk[2];
  logic [15:0] shv[2];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          LOWEXP[2] = '{64, 32};
  int          PER[2]    = '{67, 35};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model0(input logic [15:0] s, input logic [15:0] g);
    logic [15:0] r;
`ifdef DAC_GAIN_EN
    longint p;
    p = longint'($signed(s)) * longint'({16'h0, g});
    p = p >>> 15;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    r = p[15:0];
`else
    r = s;
    if (g == 16'hDEAD) r = s;
`endif
    return r ^ 16'h8000;
  endfunction

  task automatic mon(input int id, input logic cs_n, input logic sclk, input logic sdo,
                     input logic fd, input logic valid, input logic ready, input logic [15:0] e);
    logic [15:0] w;
    int          qs;
    if (reset) begin
      low_c[id]     = 0;
      edge_c[id]    = 0;
      prev_cs[id]   = 1'b1;
      prev_sclk[id] = 1'b0;
      streak[id]    = 1'b0;
      if (id == 0) q0.delete(); else q1.delete();
      return;
    end
    if (valid && ready) begin
      if (id == 0) q0.push_back(e); else q1.push_back(e);
      accepts[id]++;
      if (streak[id]) check("accept_period", cyc - last_acc[id], PER[id]);
      streak[id]   = 1'b1;
      last_acc[id] = cyc;
    end else if (!valid) begin
      streak[id] = 1'b0;
    end
    if (fd) fd_c[id]++;
    if (!cs_n) begin
      low_c[id]++;
      if (sclk && !prev_sclk[id]) begin
        shv[id] = {shv[id][14:0], sdo};
        edge_c[id]++;
      end
    end
    if (cs_n && !prev_cs[id]) begin
      frames[id]++;
      check("frame_done_at_end", fd, 1);
      check("sclk_idle_in_gap", sclk, 0);
      check("sdo_idle_in_gap", sdo, 0);
      check("sclk_rising_edges", edge_c[id], 16);
      check("cs_low_cycles", low_c[id], LOWEXP[id]);
      qs = (id == 0) ? q0.size() : q1.size();
      check("frame_expected", qs, 1);
      if (qs > 0) begin
        w = (id == 0) ? q0.pop_front() : q1.pop_front();
        check(id == 0 ? "word_dut0" : "word_dut1", shv[id], w);
      end
      low_c[id]  = 0;
      edge_c[id] = 0;
    end
    prev_cs[id]   = cs_n;
    prev_sclk[id] = sclk;
  endtask

  always @(negedge clk) begin
    mon(0, cs0, sclk0, sdo0, fd0, valid0, ready0, exp0);
    mon(1, cs1, sclk1, sdo1, fd1, valid1, ready1, exp1);
  end

  task automatic send(input int id, input logic [15:0] s, input logic [15:0] g, input logic [15:0] e);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (id == 0) begin valid0 = 1'b1; sample0 = s; gain0 = g; exp0 = e; end
    else         begin valid1 = 1'b1; sample1 = s; gain1 = g; exp1 = e; end
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = (id == 0) ? ready0 : ready1;
    end
    if (!got) check("accept_timeout", got, 1);
    @(posedge clk); #1;
    // Scramble inputs right after the accept: the frame in flight must not change.
    if (id == 0) begin valid0 = 1'b0; sample0 = 16'($urandom); gain0 = 16'($urandom); end
    else         begin valid1 = 1'b0; sample1 = 16'($urandom); gain1 = 16'($urandom); end
  endtask

  task automatic wait_frames(input int id, input int target);
    for (int k = 0; k < 600 && frames[id] < target; k++) @(negedge clk);
    check("frame_complete", frames[id] >= target, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic send_wait(input int id, input logic [15:0] s, input logic [15:0] g, input logic [15:0] e);
    int fr = frames[id];
    send(id, s, g, e);
    wait_frames(id, fr + 1);
  endtask

  vec_t tbl[9];

  initial begin
    int a, fr;
    tbl[0] = '{16'h1234, 16'h8000, 16'h9234};
    tbl[1] = '{16'h0000, 16'h8000, 16'h8000};
    tbl[2] = '{16'h7FFF, 16'h8000, 16'hFFFF};
    tbl[3] = '{16'h8000, 16'h8000, 16'h0000};
    tbl[4] = '{16'hFFFF, 16'h8000, 16'h7FFF};
    tbl[5] = '{16'hA5A5, 16'h8000, 16'h25A5};
`ifdef DAC_GAIN_EN
    tbl[6] = '{16'h7FFE, 16'h4000, 16'hBFFF};
    tbl[7] = '{16'h6000, 16'hFFFF, 16'hFFFF};
    tbl[8] = '{16'h8000, 16'hFFFF, 16'h0000};
`else
    tbl[6] = '{16'h7FFE, 16'h4000, 16'hFFFE};
    tbl[7] = '{16'h6000, 16'hFFFF, 16'hE000};
    tbl[8] = '{16'h8000, 16'hFFFF, 16'h0000};
`endif

    reset = 1'b1; valid0 = 1'b1; sample0 = 16'h1234; gain0 = 16'h8000; exp0 = 16'h0;
    valid1 = 1'b0; sample1 = 16'h0; gain1 = 16'h0; exp1 = 16'h0;
    for (int i = 0; i < 2; i++) begin
      low_c[i] = 0; edge_c[i] = 0; frames[i] = 0; fd_c[i] = 0; accepts[i] = 0; last_acc[i] = 0;
      streak[i] = 1'b0; prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; shv[i] = 16'h0;
    end

    // Reset held with valid high: outputs idle, not ready.
    repeat (3) @(posedge clk);
    #1;
    check("reset_cs_n", cs0, 1);
    check("reset_sclk", sclk0, 0);
    check("reset_sdo", sdo0, 0);
    check("reset_frame_done", fd0, 0);
    check("reset_ready", ready0, 0);
    check("reset_cs_n_dut1", cs1, 1);
    reset = 1'b0; valid0 = 1'b0;
    @(negedge clk);
    check("ready_after_reset", ready0, 1);
    check("ready_after_reset_dut1", ready1, 1);

    for (int i = 0; i < 9; i++) send_wait(0, tbl[i].smp, tbl[i].gn, tbl[i].exp);

    // Valid held: two accepts 67 cycles apart.
    @(posedge clk); #1;
    valid0 = 1'b1; sample0 = 16'h1234; gain0 = 16'h8000; exp0 = 16'h9234;
    a = accepts[0]; fr = frames[0];
    for (int k = 0; k < 300 && accepts[0] < a + 2; k++) @(negedge clk);
    check("held_valid_accepts", accepts[0] - a, 2);
    @(posedge clk); #1;
    valid0 = 1'b0;
    wait_frames(0, fr + 2);

    send_wait(1, 16'h8001, 16'h0000, 16'h8001);
    send_wait(1, 16'h1234, 16'hFFFF, 16'h1234);

    // Back-to-back stream with a new sample every cycle: only accept-cycle samples go out.
    a = accepts[0]; fr = frames[0];
    for (int k = 0; k < 210; k++) begin
      @(posedge clk); #1;
      valid0  = 1'b1;
      sample0 = 16'($urandom);
`ifdef DAC_GAIN_EN
      gain0   = 16'($urandom);
`else
      gain0   = 16'h8000;
`endif
      exp0    = model0(sample0, gain0);
    end
    @(posedge clk); #1;
    valid0 = 1'b0;
    check("decimated_accepts", accepts[0] - a, 4);
    wait_frames(0, fr + (accepts[0] - a));

    // Reset around bit 7 aborts the frame; the next frame is intact.
    fr = frames[0];
    send(0, 16'h0F0F, 16'h8000, 16'h8F0F);
    for (int k = 0; k < 200 && edge_c[0] < 7; k++) @(negedge clk);
    check("reached_bit7", edge_c[0], 7);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_cs_n", cs0, 1);
    check("abort_sclk", sclk0, 0);
    check("abort_sdo", sdo0, 0);
    check("abort_ready_in_reset", ready0, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", ready0, 1);
    check("abort_no_frame", frames[0], fr);
    send_wait(0, 16'h5A5A, 16'h8000, 16'hDA5A);

    check("frame_done_pulses_dut0", fd_c[0], frames[0]);
    check("frame_done_pulses_dut1", fd_c[1], frames[1]);
    check("scoreboard_empty", q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
